// File: rtl/pipeline_flow_controller.sv
// pipeline_flow_controller: stall/flush sequencer for the 5-stage MIPS pipeline.
// Merges debug run/step commands, load-use stalls, taken-branch flushes and
// HALT detection into per-stage enable/flush strobes; drains the pipe on HALT.
// Optional feature macro: PIPE_FLOW_CYCLE_COUNT_EN (advance-cycle counter;
// when undefined, cycle_count is tied to 0).
module pipeline_flow_controller #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run_req,
    input  logic                 step_req,
    input  logic                 halt_detected,
    input  logic                 load_use_stall,
    input  logic                 branch_taken,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 back_en,
    output logic                 halted,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic           advance;

    // State and drain counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic; the drain counter is loaded on DRAIN entry
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (run_req) begin
                    state_d = S_RUN;
                end else if (step_req) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (halt_detected) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (!run_req) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                if (halt_detected) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_HALTED;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Per-stage strobes: combinational from state and hazard inputs
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        back_en     = 1'b0;
        advance     = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
        if (state_q == S_DRAIN) begin
            // Front end is fed bubbles while older instructions retire
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            back_en     = 1'b1;
        end else if (advance) begin
            back_en = 1'b1;
            if (branch_taken) begin
                // Stalled ID instruction is wrong-path, so the flush wins
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use_stall) begin
                id_ex_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
            end
        end
    end

    assign halted = (state_q == S_HALTED);
    assign busy   = advance;

`ifdef PIPE_FLOW_CYCLE_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Advance-cycle counter, wraps naturally
    always_comb begin
        cnt_d = cnt_q;
        if (advance) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_count = cnt_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_flow_controller.sv
// Scoreboard bench for pipeline_flow_controller: directed per-cycle vectors
// push hand-computed expectations; a negedge monitor pops and compares.
module tb_pipeline_flow_controller;

    localparam logic [4:0] OFF  = 5'b00000; // {pc_en,if_id_en,if_id_flush,id_ex_flush,back_en}
    localparam logic [4:0] NORM = 5'b11001;
    localparam logic [4:0] STL  = 5'b00011;
    localparam logic [4:0] BRF  = 5'b11111;
    localparam logic [4:0] DRN  = 5'b01101;

    typedef struct packed {
        logic [4:0]  st;
        logic        h;
        logic        b;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        run_req, step_req, halt_detected, load_use_stall, branch_taken;
    logic        pc_en, if_id_en, if_id_flush, id_ex_flush, back_en, halted, busy;
    logic [31:0] cycle_count;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   vec_no;

    pipeline_flow_controller #(
        .DRAIN_CYCLES (4),
        .CNT_WIDTH    (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run_req        (run_req),
        .step_req       (step_req),
        .halt_detected  (halt_detected),
        .load_use_stall (load_use_stall),
        .branch_taken   (branch_taken),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .back_en        (back_en),
        .halted         (halted),
        .busy           (busy),
        .cycle_count    (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the edge and queue its expectation
    task automatic vec(input logic rs, input logic rn, input logic sp, input logic ht,
                       input logic lu, input logic br, input logic [4:0] st,
                       input logic h, input logic b, input int unsigned cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = rs;
        run_req        = rn;
        step_req       = sp;
        halt_detected  = ht;
        load_use_stall = lu;
        branch_taken   = br;
        e.st  = st;
        e.h   = h;
        e.b   = b;
`ifdef PIPE_FLOW_CYCLE_COUNT_EN
        e.cnt = cnt;
`else
        e.cnt = (cnt > 0) ? 32'd0 : 32'd0;
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0] st;
            e  = exp_q.pop_front();
            st = {pc_en, if_id_en, if_id_flush, id_ex_flush, back_en};
            vec_no++;
            total++;
            if (st !== e.st) begin
                bad++;
                $display("FAIL strobes vec=%0d got=%b want=%b", vec_no, st, e.st);
            end
            total++;
            if (halted !== e.h) begin
                bad++;
                $display("FAIL halted vec=%0d got=%b want=%b", vec_no, halted, e.h);
            end
            total++;
            if (busy !== e.b) begin
                bad++;
                $display("FAIL busy vec=%0d got=%b want=%b", vec_no, busy, e.b);
            end
            total++;
            if (cycle_count !== e.cnt) begin
                bad++;
                $display("FAIL cycle_count vec=%0d got=%0d want=%0d", vec_no, cycle_count, e.cnt);
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        vec_no = 0;
        rst_n = 1'b0;
        run_req = 1'b0;
        step_req = 1'b0;
        halt_detected = 1'b0;
        load_use_stall = 1'b0;
        branch_taken = 1'b0;

        //  rs rn sp ht lu br  strobe h  b  cnt
        // Reset, then ten run cycles; run_req drops in the tenth
        vec(0, 0, 0, 0, 0, 0, OFF,  0, 0, 0);
        vec(1, 1, 0, 0, 0, 0, OFF,  0, 0, 0);
        for (int i = 0; i < 9; i++) vec(1, 1, 0, 0, 0, 0, NORM, 0, 1, i);
        vec(1, 0, 0, 0, 0, 0, NORM, 0, 1, 9);
        vec(1, 0, 0, 0, 0, 0, OFF,  0, 0, 10);
        // Load-use stall, then stall+branch and branch alone
        vec(1, 1, 0, 0, 0, 0, OFF,  0, 0, 10);
        vec(1, 1, 0, 0, 0, 0, NORM, 0, 1, 10);
        vec(1, 1, 0, 0, 1, 0, STL,  0, 1, 11);
        vec(1, 1, 0, 0, 0, 0, NORM, 0, 1, 12);
        vec(1, 1, 0, 0, 1, 1, BRF,  0, 1, 13);
        vec(1, 1, 0, 0, 0, 1, BRF,  0, 1, 14);
        vec(1, 0, 0, 0, 0, 0, NORM, 0, 1, 15);
        // step_req held: IDLE/STEP alternation
        vec(1, 0, 1, 0, 0, 0, OFF,  0, 0, 16);
        vec(1, 0, 1, 0, 0, 0, NORM, 0, 1, 16);
        vec(1, 0, 1, 0, 0, 0, OFF,  0, 0, 17);
        vec(1, 0, 0, 0, 0, 0, NORM, 0, 1, 17);
        vec(1, 0, 0, 0, 0, 0, OFF,  0, 0, 18);
        // Reset, then three step pulses four cycles apart
        vec(0, 0, 0, 0, 0, 0, OFF,  0, 0, 0);
        vec(1, 0, 1, 0, 0, 0, OFF,  0, 0, 0);
        vec(1, 0, 0, 0, 0, 0, NORM, 0, 1, 0);
        vec(1, 0, 0, 0, 0, 0, OFF,  0, 0, 1);
        vec(1, 0, 0, 0, 0, 0, OFF,  0, 0, 1);
        vec(1, 0, 1, 0, 0, 0, OFF,  0, 0, 1);
        vec(1, 0, 0, 0, 0, 0, NORM, 0, 1, 1);
        vec(1, 0, 0, 0, 0, 0, OFF,  0, 0, 2);
        vec(1, 0, 0, 0, 0, 0, OFF,  0, 0, 2);
        vec(1, 0, 1, 0, 0, 0, OFF,  0, 0, 2);
        vec(1, 0, 0, 0, 0, 0, NORM, 0, 1, 2);
        vec(1, 0, 0, 0, 0, 0, OFF,  0, 0, 3);
        // run+step together picks RUN; HALT drains four cycles then freezes
        vec(1, 1, 1, 0, 0, 0, OFF,  0, 0, 3);
        vec(1, 1, 0, 0, 0, 0, NORM, 0, 1, 3);
        vec(1, 1, 0, 1, 0, 0, NORM, 0, 1, 4);
        vec(1, 1, 0, 0, 1, 1, DRN,  0, 1, 5);
        vec(1, 1, 0, 0, 0, 0, DRN,  0, 1, 6);
        vec(1, 1, 0, 0, 0, 0, DRN,  0, 1, 7);
        vec(1, 1, 0, 0, 0, 0, DRN,  0, 1, 8);
        vec(1, 1, 1, 0, 0, 0, OFF,  1, 0, 9);
        vec(1, 1, 0, 0, 1, 1, OFF,  1, 0, 9);
        vec(1, 0, 1, 0, 0, 0, OFF,  1, 0, 9);
        // Reset out of HALTED; HALT in a STEP; reset in drain cycle 2
        vec(0, 0, 0, 0, 0, 0, OFF,  0, 0, 0);
        vec(1, 0, 1, 0, 0, 0, OFF,  0, 0, 0);
        vec(1, 0, 0, 1, 0, 0, NORM, 0, 1, 0);
        vec(1, 0, 0, 0, 0, 0, DRN,  0, 1, 1);
        vec(0, 0, 0, 0, 0, 0, OFF,  0, 0, 0);
        vec(1, 0, 0, 0, 0, 0, OFF,  0, 0, 0);
        vec(1, 0, 0, 0, 0, 0, OFF,  0, 0, 0);
        vec(1, 1, 0, 0, 0, 0, OFF,  0, 0, 0);
        vec(1, 0, 0, 0, 0, 0, NORM, 0, 1, 0);
        vec(1, 0, 0, 0, 0, 0, OFF,  0, 0, 1);

        // Bounded wait for the monitor to drain the scoreboard
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
